// File: rtl/down_counter_pkg.sv
// Shared counter constants for counter/down_counter instances.
// Pure declarations; no logic, no latency, no flow control.
package down_counter_pkg;
  localparam int DEFAULT_SIZE = 10;
endpackage

// File: rtl/down_counter_decrementer.sv
// Subtract-one ripple chain: value + all-ones through fa cells; bo flags value == 0.
// Purely combinational; no state, no flow control.
module down_counter_decrementer
  import down_counter_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic [SIZE-1:0] value,
  output logic [SIZE-1:0] dec_value,
  output logic            bo
);
  logic [SIZE:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    fa u_fa (
      .a    (value[i]),
      .b    (1'b1),
      .cin  (carry[i]),
      .s    (dec_value[i]),
      .cout (carry[i+1])
    );
  end

  // Adding all-ones only fails to carry out when the input was zero.
  assign bo = ~carry[SIZE];
endmodule

// File: rtl/fa.sv
// Single-bit full adder cell used to build ripple arithmetic chains.
// Purely combinational; no state, no flow control.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/n_bit_reg.sv
// Enabled N-bit register with synchronous active-high reset to zero.
// Latency 1 cycle from pin/pen to pout; holds when pen is low.
module n_bit_reg
  import down_counter_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pen,
  input  logic [SIZE-1:0] pin,
  output logic [SIZE-1:0] pout
);
  logic [SIZE-1:0] pout_q;
  logic [SIZE-1:0] pout_d;

  assign pout_d = pen ? pin : pout_q;

  always_ff @(posedge clk) begin
    if (rst) pout_q <= '0;
    else     pout_q <= pout_d;
  end

  assign pout = pout_q;
endmodule

// File: rtl/down_counter.sv
// Loadable down-counter, priority rst > ld > dec > hold; DOWN_COUNTER_SATURATE_EN clamps at 0 instead of wrapping.
// Latency 1 cycle from ld/dec to count; zero/bo follow count combinationally; accepts ld/dec every cycle.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [SIZE-1:0] ld_val,
  input  logic            dec,
  output logic [SIZE-1:0] count,
  output logic            zero,
  output logic            bo
);
  logic [SIZE-1:0] dec_value;
  logic [SIZE-1:0] count_d;
  logic            pen;

  down_counter_decrementer #(.SIZE(SIZE)) u_dec (
    .value     (count),
    .dec_value (dec_value),
    .bo        (bo)
  );

  assign count_d = ld ? ld_val : dec_value;

`ifdef DOWN_COUNTER_SATURATE_EN
  // A bare decrement at zero must not write, so the register keeps 0.
  assign pen = (ld | dec) & ~(dec & ~ld & zero);
`else
  assign pen = ld | dec;
`endif

  n_bit_reg #(.SIZE(SIZE)) u_reg (
    .clk  (clk),
    .rst  (rst),
    .pen  (pen),
    .pin  (count_d),
    .pout (count)
  );

  assign zero = (count == '0);
endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: expected counts queued at drive time, popped after each edge.
module tb_down_counter;
  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         dec;
  logic [W-1:0] count;
  logic         zero;
  logic         bo;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;
  int           total;
  int           bad;

  down_counter #(.SIZE(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .ld_val (ld_val),
    .dec    (dec),
    .count  (count),
    .zero   (zero),
    .bo     (bo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired count=%0d", count);
    $fatal(1, "watchdog");
  end

  // Drive one cycle, push the behavioural expectation, sample 1 time unit after the edge.
  task automatic drive(input logic r, input logic l, input logic [W-1:0] v, input logic d);
    rst = r; ld = l; ld_val = v; dec = d;
    if (r)      model = '0;
    else if (l) model = v;
    else if (d) begin
`ifdef DOWN_COUNTER_SATURATE_EN
      if (model != '0) model = model - 1'b1;
`else
      model = model - 1'b1;
`endif
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    rst = 1'b0; ld = 1'b0; dec = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      total++;
      if (count !== e || count !== '0) begin
        bad++; $display("FAIL reset_count cyc=%0d got=%0d exp=%0d", i, count, e);
      end
      total++;
      if (zero !== 1'b1 || bo !== 1'b1) begin
        bad++; $display("FAIL reset_flags cyc=%0d got zero=%b bo=%b exp zero=1 bo=1", i, zero, bo);
      end
      if (i < 3) drive(1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_load_countdown();
    logic [W-1:0] e;
    logic [W-1:0] want [6];
    want = '{10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0};
    drive(1'b0, 1'b1, 10'd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      total++;
      if (count !== e || count !== want[i]) begin
        bad++; $display("FAIL countdown_count step=%0d got=%0d exp=%0d", i, count, want[i]);
      end
      total++;
      if (zero !== (i == 5) || bo !== (i == 5)) begin
        bad++; $display("FAIL countdown_flags step=%0d got zero=%b bo=%b exp=%b", i, zero, bo, (i == 5));
      end
      if (i < 5) drive(1'b0, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    logic         exp_flag;
    drive(1'b0, 1'b0, '0, 1'b1);
    e = exp_q.pop_front();
`ifdef DOWN_COUNTER_SATURATE_EN
    exp_flag = 1'b1;
    total++;
    if (count !== e || count !== 10'd0) begin
      bad++; $display("FAIL saturate_count got=%0d exp=0", count);
    end
`else
    exp_flag = 1'b0;
    total++;
    if (count !== e || count !== 10'd1023) begin
      bad++; $display("FAIL wrap_count got=%0d exp=1023", count);
    end
`endif
    total++;
    if (zero !== exp_flag || bo !== exp_flag) begin
      bad++; $display("FAIL wrap_flags got zero=%b bo=%b exp=%b", zero, bo, exp_flag);
    end
  endtask

  task automatic test_priority();
    logic [W-1:0] e;
    drive(1'b0, 1'b1, 10'd7, 1'b0);
    e = exp_q.pop_front();
    total++;
    if (count !== e) begin
      bad++; $display("FAIL prio_preload got=%0d exp=%0d", count, e);
    end
    drive(1'b0, 1'b1, 10'd3, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (count !== e || count !== 10'd3) begin
      bad++; $display("FAIL prio_ld_over_dec got=%0d exp=3", count);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] e;
    drive(1'b0, 1'b1, 10'd9, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 10'd1, 1'b0);
      e = exp_q.pop_front();
      total++;
      if (count !== e || count !== 10'd9 || zero !== 1'b0 || bo !== 1'b0) begin
        bad++; $display("FAIL hold cyc=%0d got=%0d zero=%b bo=%b exp=9 zero=0 bo=0", i, count, zero, bo);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] e;
    drive(1'b0, 1'b1, 10'd500, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      void'(exp_q.pop_front());
    end
    total++;
    if (count !== 10'd490) begin
      bad++; $display("FAIL midrst_before got=%0d exp=490", count);
    end
    drive(1'b1, 1'b1, 10'd77, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (count !== e || count !== 10'd0 || zero !== 1'b1 || bo !== 1'b1) begin
      bad++; $display("FAIL midrst_edge got=%0d zero=%b bo=%b exp=0 zero=1 bo=1", count, zero, bo);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    e = exp_q.pop_front();
    total++;
`ifdef DOWN_COUNTER_SATURATE_EN
    if (count !== e || count !== 10'd0) begin
      bad++; $display("FAIL midrst_after got=%0d exp=0", count);
    end
`else
    if (count !== e || count !== 10'd1023) begin
      bad++; $display("FAIL midrst_after got=%0d exp=1023", count);
    end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [W-1:0] v;
    int           op;
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 19));
      v  = W'($urandom_range(0, 15)) | ((op == 1) ? 10'h3F0 : 10'h000);
      drive(op == 0, op < 3, v, op[0] | (op > 8));
      e = exp_q.pop_front();
      total++;
      if (count !== e || zero !== (e == '0) || bo !== (e == '0)) begin
        bad++; $display("FAIL random i=%0d got=%0d zero=%b bo=%b exp=%0d", i, count, zero, bo, e);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; model = '0;
    rst = 1'b0; ld = 1'b0; ld_val = '0; dec = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_countdown();
    test_wrap();
    test_priority();
    test_hold();
    test_reset_mid_count();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter with borrow-out; the decrementing counterpart of the team's up-counter.
- Used for loop/terminal-count control, e.g. counting remaining words or cycles down to zero.
- Built structurally from the existing fa cells, configured as a subtract-one ripple chain, and the existing n_bit_reg.
- A load path presets the start value; bo/zero flag the terminal count.

Parameters:
SIZE, 10, counter width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
ld  input  1  load enable; count <= ld_val on next edge.
ld_val  input  SIZE  preset value.
dec  input  1  decrement enable.
count  output  SIZE  current counter value (registered).
zero  output  1  high when count == 0 (combinational from register).
bo  output  1  borrow-out of decrement chain; high when count == 0, independent of dec.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On a rising edge with rst=1, count <= 0; consequently zero=1 and bo=1 after reset.
- Priority per edge: rst > ld > dec > hold.
  - ld=1: count <= ld_val, regardless of dec.
  - dec=1 and ld=0: count <= count - 1 (mod 2^SIZE).
  - Neither: count holds.
- Decrement arithmetic: computed as count + all-ones.
  - Per-bit fa with b=1'b1; carry[0]=1'b0; carry[i+1] chains.
  - bo = ~carry[SIZE], i.e. high exactly when count == 0.
- Register write enable: pen = ld | dec. The register input mux selects ld_val when ld=1, else the decremented value.
- Latency: one cycle from ld/dec sampled to new count visible. zero/bo follow count combinationally in the same cycle.
- Wrap-around (default): dec at count=0 gives count = 2^SIZE-1 (1023 for SIZE=10); bo was 1 during that cycle.
- Simultaneous ld and dec: load wins, no decrement applied.
- ld_val=0: zero=1 the cycle after the load.
- Reset mid-count: count=0 on the reset edge; ld/dec in that cycle are ignored.
- No X propagation: all outputs are defined from the first reset onward.

Optional Feature:
- Macro: DOWN_COUNTER_SATURATE_EN.
- Defined:
  - dec at count=0 holds count at 0; no wrap.
  - Achieved by gating pen with ~(dec & ~ld & zero).
  - bo and zero still assert at 0.
- Undefined: modulo wrap as above.
- ld and rst behaviour are identical in both builds.

Decomposition:
- Shared constants file: default counter width (10), reused by counter and down_counter instances.
- One natural sub-module: decrementer #(SIZE).
  - Generate loop of fa cells with b=1'b1 and cin chain starting at 0.
  - Outputs dec_value[SIZE-1:0] and bo.
- down_counter = decrementer + 2:1 input mux + n_bit_reg (pen, pin, pout).

Test Plan:
- Reset: rst=1 for 1 edge -> count=0, zero=1, bo=1; rst=0, no ld/dec for 3 cycles -> count stays 0.
- Load then count down: ld=1, ld_val=5 for 1 cycle, then dec=1 for 5 cycles -> count 5,4,3,2,1,0; zero=1 and bo=1 only in the final cycle.
- Wrap: count=0, dec=1 for 1 cycle -> count=1023, bo=0, zero=0. With DOWN_COUNTER_SATURATE_EN -> count stays 0.
- Priority: count=7, ld=1, ld_val=3, dec=1 for the same cycle -> count=3, not 2 or 6.
- Hold: count=9, dec=0, ld=0 for 4 cycles -> count=9 throughout.
- Reset mid-count: load 500, dec for 10 cycles (count=490), then rst=1 with dec=1 -> count=0 on that edge; next cycle with dec=1 -> 1023 (wrap build) or 0 (saturate build).
